// File: rtl/avl_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : avl_sram_responder_if
// Brief    : AVL request/response bus bundle between a master and a responder.
// Revision : 1.0
// ============================================================================
interface avl_sram_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) ();
    logic              avl_burstbegin;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_write;
    logic              avl_read;
    logic              avl_wait_request_n;
    logic              avl_readdatavalid;
    logic [DATA_W-1:0] avl_readdata;

    modport master (
        output avl_burstbegin,
        output avl_address,
        output avl_writedata,
        output avl_write,
        output avl_read,
        input  avl_wait_request_n,
        input  avl_readdatavalid,
        input  avl_readdata
    );

    modport slave (
        input  avl_burstbegin,
        input  avl_address,
        input  avl_writedata,
        input  avl_write,
        input  avl_read,
        output avl_wait_request_n,
        output avl_readdatavalid,
        output avl_readdata
    );
endinterface
`default_nettype wire

// File: rtl/avl_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : avl_sram_responder
// Brief    : On-chip RAM responder on the AVL bus: zero-clear init, fixed read
//            latency, optional LFSR-driven back-pressure.
// Revision : 1.0
// ============================================================================
module avl_sram_responder #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 64,
    parameter int          READ_LAT   = 4,
    parameter int          STALL_RATE = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  wire                        iCLK,
    input  wire                        iRST,
    avl_sram_responder_if.slave        avl,
    output logic                       local_init_done,
    output logic                       oERR,
    output logic [15:0]                oRD_CNT,
    output logic [15:0]                oWR_CNT
);

    localparam int         c_depth = 1 << ADDR_W;
    localparam logic [4:0] c_stall = 5'(STALL_RATE);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_clear_en;
    logic [ADDR_W:0]     r_clr_cnt;

    logic [15:0]         r_lfsr;
    logic                w_lfsr_fb;
    logic                w_stall;

    logic                r_ready;
    logic                r_init_done;
    logic                r_err;
    logic [15:0]         r_rd_cnt;
    logic [15:0]         r_wr_cnt;

    logic                w_req;
    logic                w_accept;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_err_evt;

    logic [DATA_W-1:0]   r_mem [c_depth];

    logic [READ_LAT-1:0] r_vpipe;
    logic [DATA_W-1:0]   r_dpipe [READ_LAT];
    logic [READ_LAT-1:0] w_stg_v;
    logic [DATA_W-1:0]   w_stg_d [READ_LAT];

    logic                w_unused_burst;

    // Transfers are always single-beat, so the burst marker carries no meaning.
    assign w_unused_burst = avl.avl_burstbegin;

    // ------------------------------------------------------------------------
    // Init / run state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear_en   = 1'b0;
        case (r_state)
            ST_INIT: begin
                // Top bit of the clear counter sets once every word is written.
                if (r_clr_cnt[ADDR_W]) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_clear_en = 1'b1;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_clr_cnt <= '0;
        end else if (w_clear_en) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Back-pressure generator
    // ------------------------------------------------------------------------
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_stall   = ({1'b0, r_lfsr[3:0]} < c_stall);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == ST_RUN) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_ready     <= (w_state_next == ST_RUN) && !w_stall;
            r_init_done <= (w_state_next == ST_RUN);
        end
    end

    // ------------------------------------------------------------------------
    // Request acceptance, statistics and error flag
    // ------------------------------------------------------------------------
    assign w_req     = avl.avl_read | avl.avl_write;
    assign w_accept  = w_req & r_ready & r_init_done;
    assign w_wr_acc  = w_accept & avl.avl_write;
    // A collision keeps the write and drops the read.
    assign w_rd_acc  = w_accept & avl.avl_read & ~avl.avl_write;
    assign w_err_evt = (w_accept & avl.avl_read & avl.avl_write) |
                       (w_req & ~r_init_done);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_err    <= 1'b0;
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: cleared by the init walk, no reset on the array itself
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (w_clear_en) begin
            r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
        end else if (w_wr_acc) begin
            r_mem[avl.avl_address] <= avl.avl_writedata;
        end
    end

    // ------------------------------------------------------------------------
    // Read return pipeline: each stage loads data only alongside a valid token
    // so the final stage holds the last returned word between strobes.
    // ------------------------------------------------------------------------
    assign w_stg_v[0] = w_rd_acc;
    assign w_stg_d[0] = r_mem[avl.avl_address];

    for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_link
        assign w_stg_v[gi] = r_vpipe[gi-1];
        assign w_stg_d[gi] = r_dpipe[gi-1];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_vpipe <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_dpipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_vpipe[i] <= w_stg_v[i];
                if (w_stg_v[i]) begin
                    r_dpipe[i] <= w_stg_d[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign avl.avl_wait_request_n = r_ready;
    assign avl.avl_readdatavalid  = r_vpipe[READ_LAT-1];
    assign avl.avl_readdata       = r_dpipe[READ_LAT-1];
    assign local_init_done        = r_init_done;
    assign oERR                   = r_err;
    assign oRD_CNT                = r_rd_cnt;
    assign oWR_CNT                = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_avl_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_avl_sram_responder
// Brief    : Randomised self-checking bench with a memory/queue reference model.
// Revision : 1.0
// ============================================================================
module tb_avl_sram_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int LAT    = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avl_sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    avl_sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus8 ();

    logic        done0, err0, done8, err8;
    logic [15:0] rdc0, wrc0, rdc8, wrc8;

    avl_sram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(LAT),
                         .STALL_RATE(0), .LFSR_SEED(16'hACE1)) u_dut0 (
        .iCLK(clk), .iRST(rst), .avl(bus0.slave), .local_init_done(done0),
        .oERR(err0), .oRD_CNT(rdc0), .oWR_CNT(wrc0)
    );

    avl_sram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(LAT),
                         .STALL_RATE(8), .LFSR_SEED(16'hACE1)) u_dut8 (
        .iCLK(clk), .iRST(rst), .avl(bus8.slave), .local_init_done(done8),
        .oERR(err8), .oRD_CNT(rdc8), .oWR_CNT(wrc8)
    );

    // Reference model: flat memories, expected/observed return queues, counts
    logic [DATA_W-1:0] ref0 [DEPTH];
    logic [DATA_W-1:0] ref8 [DEPTH];
    beat_t exp0[$], rx0[$], exp8[$], rx8[$];
    int    wr0_n, rd0_n, wr8_n, rd8_n;

    always @(negedge clk) begin
        if (bus0.avl_readdatavalid) rx0.push_back('{cyc: cyc, data: bus0.avl_readdata});
        if (bus8.avl_readdatavalid) rx8.push_back('{cyc: cyc, data: bus8.avl_readdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.avl_burstbegin = 1'b0; bus0.avl_address = '0; bus0.avl_writedata = '0;
        bus0.avl_write = 1'b0; bus0.avl_read = 1'b0;
        bus8.avl_burstbegin = 1'b0; bus8.avl_address = '0; bus8.avl_writedata = '0;
        bus8.avl_write = 1'b0; bus8.avl_read = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ref0[i] = '0;
            ref8[i] = '0;
        end
        exp0.delete(); rx0.delete(); exp8.delete(); rx8.delete();
        wr0_n = 0; rd0_n = 0; wr8_n = 0; rd8_n = 0;
    endtask

    task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        bus0.avl_write = 1'b1; bus0.avl_burstbegin = 1'b1;
        bus0.avl_address = a; bus0.avl_writedata = d;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (bus0.avl_wait_request_n && done0) ok = 1'b1;
            tick();
            bus0.avl_burstbegin = 1'b0;
        end
        bus0.avl_write = 1'b0;
        if (ok) begin
            ref0[a] = d;
            wr0_n++;
        end else begin
            vectors++; miscompares++;
            $display("FAIL wr0_accept addr=%h: accepted=0 required=1", a);
        end
    endtask

    task automatic rd0(input logic [ADDR_W-1:0] a);
        bit ok = 1'b0;
        bus0.avl_read = 1'b1; bus0.avl_burstbegin = 1'b1; bus0.avl_address = a;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (bus0.avl_wait_request_n && done0) begin
                ok = 1'b1;
                exp0.push_back('{cyc: cyc + LAT, data: ref0[a]});
            end
            tick();
            bus0.avl_burstbegin = 1'b0;
        end
        bus0.avl_read = 1'b0;
        if (ok) begin
            rd0_n++;
        end else begin
            vectors++; miscompares++;
            $display("FAIL rd0_accept addr=%h: accepted=0 required=1", a);
        end
    endtask

    task automatic test_reset();
        int t0;
        rst = 1'b1;
        idle_all();
        model_reset();
        repeat (3) tick();
        vectors++;
        if ({done0, bus0.avl_wait_request_n, bus0.avl_readdatavalid, err0} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got done/ready/valid/err=%b required 0000",
                     {done0, bus0.avl_wait_request_n, bus0.avl_readdatavalid, err0});
        end
        vectors++;
        if ({bus0.avl_readdata, rdc0, wrc0} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got rdata=%h rd=%0d wr=%0d required zeros",
                     bus0.avl_readdata, rdc0, wrc0);
        end
        rst = 1'b0;
        t0  = cyc;
        for (int k = 0; k < 400 && !done0; k++) tick();
        vectors++;
        if (cyc - t0 !== 257) begin
            miscompares++;
            $display("FAIL init_done_edge got %0d required 257", cyc - t0);
        end
        vectors++;
        if ({bus0.avl_wait_request_n, done8} !== 2'b11) begin
            miscompares++;
            $display("FAIL init_ready got ready0/done8=%b required 11",
                     {bus0.avl_wait_request_n, done8});
        end
        rd0(8'h37);
        repeat (LAT + 2) tick();
        vectors++;
        if (rx0.size() !== 1 || exp0.size() !== 1) begin
            miscompares++;
            $display("FAIL init_read_count got %0d required 1", rx0.size());
        end else begin
            vectors++;
            if (rx0[0].cyc !== exp0[0].cyc || rx0[0].data !== exp0[0].data) begin
                miscompares++;
                $display("FAIL init_read got cyc=%0d data=%h required cyc=%0d data=%h",
                         rx0[0].cyc, rx0[0].data, exp0[0].cyc, exp0[0].data);
            end
        end
        rx0.delete(); exp0.delete();
    endtask

    task automatic test_write_read();
        logic [ADDR_W-1:0] a;
        wr0(8'h10, 64'hDEAD_BEEF_0123_4567);
        rd0(8'h10);
        vectors++;
        if (wrc0 !== 16'(wr0_n) || rdc0 !== 16'(rd0_n)) begin
            miscompares++;
            $display("FAIL wr_rd_counts got wr=%0d rd=%0d required wr=%0d rd=%0d",
                     wrc0, rdc0, wr0_n, rd0_n);
        end
        for (int n = 0; n < 12; n++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 2) != 0) wr0(a, {$urandom(), $urandom()});
            rd0(a);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (LAT + 2) tick();
        vectors++;
        if (rx0.size() !== exp0.size()) begin
            miscompares++;
            $display("FAIL wr_rd_returns got %0d required %0d", rx0.size(), exp0.size());
        end
        for (int i = 0; i < rx0.size() && i < exp0.size(); i++) begin
            vectors++;
            if (rx0[i].cyc !== exp0[i].cyc || rx0[i].data !== exp0[i].data) begin
                miscompares++;
                $display("FAIL wr_rd_beat%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                         i, rx0[i].cyc, rx0[i].data, exp0[i].cyc, exp0[i].data);
            end
        end
        vectors++;
        if (wrc0 !== 16'(wr0_n) || rdc0 !== 16'(rd0_n)) begin
            miscompares++;
            $display("FAIL wr_rd_counts_end got wr=%0d rd=%0d required wr=%0d rd=%0d",
                     wrc0, rdc0, wr0_n, rd0_n);
        end
        rx0.delete(); exp0.delete();
    endtask

    task automatic test_streaming();
        for (int a = 0; a < 16; a++) wr0(ADDR_W'(a), DATA_W'(a));
        for (int a = 0; a < 16; a++) rd0(ADDR_W'(a));
        repeat (LAT + 2) tick();
        vectors++;
        if (rx0.size() !== 16 || exp0.size() !== 16) begin
            miscompares++;
            $display("FAIL stream_returns got %0d required 16", rx0.size());
        end
        for (int i = 0; i < rx0.size() && i < exp0.size(); i++) begin
            vectors++;
            if (rx0[i].cyc !== exp0[i].cyc || rx0[i].data !== exp0[i].data) begin
                miscompares++;
                $display("FAIL stream_beat%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                         i, rx0[i].cyc, rx0[i].data, exp0[i].cyc, exp0[i].data);
            end
        end
        vectors++;
        if (bus0.avl_readdatavalid !== 1'b0 || bus0.avl_readdata !== 64'd15) begin
            miscompares++;
            $display("FAIL stream_hold got valid=%b data=%h required valid=0 data=f",
                     bus0.avl_readdatavalid, bus0.avl_readdata);
        end
        rx0.delete(); exp0.delete();
    endtask

    task automatic test_back_pressure();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit ok;
        int stalls = 0;
        for (int n = 0; n < 400; n++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            d = {$urandom(), $urandom()};
            bus8.avl_address = a;
            bus8.avl_writedata = d;
            if (n < 200) bus8.avl_write = 1'b1;
            else         bus8.avl_read  = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 64 && !ok; k++) begin
                if (bus8.avl_wait_request_n) begin
                    ok = 1'b1;
                    if (n >= 200) exp8.push_back('{cyc: cyc + LAT, data: ref8[a]});
                end else begin
                    stalls++;
                end
                tick();
            end
            bus8.avl_write = 1'b0;
            bus8.avl_read  = 1'b0;
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL bp_accept op=%0d: accepted=0 required=1", n);
            end else if (n < 200) begin
                ref8[a] = d;
                wr8_n++;
            end else begin
                rd8_n++;
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        repeat (LAT + 2) tick();
        vectors++;
        if (stalls == 0) begin
            miscompares++;
            $display("FAIL bp_stalls got 0 stall cycles required >0");
        end
        vectors++;
        if (rx8.size() !== exp8.size()) begin
            miscompares++;
            $display("FAIL bp_returns got %0d required %0d", rx8.size(), exp8.size());
        end
        for (int i = 0; i < rx8.size() && i < exp8.size(); i++) begin
            vectors++;
            if (rx8[i].cyc !== exp8[i].cyc || rx8[i].data !== exp8[i].data) begin
                miscompares++;
                $display("FAIL bp_beat%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                         i, rx8[i].cyc, rx8[i].data, exp8[i].cyc, exp8[i].data);
            end
        end
        vectors++;
        if (wrc8 !== 16'(wr8_n) || rdc8 !== 16'(rd8_n) || err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_counts got wr=%0d rd=%0d err=%b required wr=%0d rd=%0d err=0",
                     wrc8, rdc8, err8, wr8_n, rd8_n);
        end
        rx8.delete(); exp8.delete();
    endtask

    task automatic test_protocol_error();
        bit ok = 1'b0;
        bus0.avl_read = 1'b1; bus0.avl_write = 1'b1;
        bus0.avl_address = 8'h20; bus0.avl_writedata = 64'h5;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (bus0.avl_wait_request_n && done0) ok = 1'b1;
            tick();
        end
        bus0.avl_read = 1'b0; bus0.avl_write = 1'b0;
        if (ok) begin
            ref0[8'h20] = 64'h5;
            wr0_n++;
        end
        repeat (LAT + 3) tick();
        vectors++;
        if (rx0.size() !== 0 || err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_flag got returns=%0d err=%b required returns=0 err=1",
                     rx0.size(), err0);
        end
        repeat (100) tick();
        vectors++;
        if (err0 !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_sticky got err=%b required 1", err0);
        end
        vectors++;
        if (wrc0 !== 16'(wr0_n)) begin
            miscompares++;
            $display("FAIL perr_wrcnt got %0d required %0d", wrc0, wr0_n);
        end
        rd0(8'h20);
        repeat (LAT + 2) tick();
        vectors++;
        if (rx0.size() !== 1 || exp0.size() !== 1) begin
            miscompares++;
            $display("FAIL perr_read_count got %0d required 1", rx0.size());
        end else begin
            vectors++;
            if (rx0[0].data !== exp0[0].data || rx0[0].cyc !== exp0[0].cyc) begin
                miscompares++;
                $display("FAIL perr_mem got cyc=%0d data=%h required cyc=%0d data=%h",
                         rx0[0].cyc, rx0[0].data, exp0[0].cyc, exp0[0].data);
            end
        end
        rx0.delete(); exp0.delete();
    endtask

    task automatic test_mid_reset();
        int t0;
        wr0(8'h10, 64'h0123_4567_89AB_CDEF);
        rd0(8'h10); rd0(8'h11); rd0(8'h10);
        rst = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        t0  = cyc;
        tick();
        // A request while the responder is still clearing must raise the error flag.
        bus8.avl_read = 1'b1;
        repeat (3) tick();
        bus8.avl_read = 1'b0;
        for (int k = 0; k < 400 && !done0; k++) tick();
        vectors++;
        if (cyc - t0 !== 257) begin
            miscompares++;
            $display("FAIL reinit_edge got %0d required 257", cyc - t0);
        end
        vectors++;
        if (rx0.size() !== 0 || rx8.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_flush got returns=%0d/%0d required 0/0", rx0.size(), rx8.size());
        end
        vectors++;
        if ({err0, err8} !== 2'b01 || rdc0 !== 16'd0 || wrc0 !== 16'd0) begin
            miscompares++;
            $display("FAIL reinit_state got err0/err8=%b rd=%0d wr=%0d required 01 0 0",
                     {err0, err8}, rdc0, wrc0);
        end
        rd0(8'h10);
        repeat (LAT + 2) tick();
        vectors++;
        if (rx0.size() !== 1 || exp0.size() !== 1) begin
            miscompares++;
            $display("FAIL reinit_read_count got %0d required 1", rx0.size());
        end else begin
            vectors++;
            if (rx0[0].data !== exp0[0].data || rx0[0].cyc !== exp0[0].cyc) begin
                miscompares++;
                $display("FAIL reinit_read got cyc=%0d data=%h required cyc=%0d data=%h",
                         rx0[0].cyc, rx0[0].data, exp0[0].cyc, exp0[0].data);
            end
        end
        rx0.delete(); exp0.delete();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_streaming();
        test_back_pressure();
        test_protocol_error();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
